// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and state encodings for the ACIA serial peer.
//   SUBBITS      oversample ticks per bit
//   DATA_BITS    data bits per 8N1 frame
//   FRAME_BITS   start + data + stop
//   START_SAMPLE sub-tick at which a start bit is re-checked
//   RATE_SLOW/RATE_FAST  rate_sel encoding
package serial_pkg;
  localparam int SUBBITS      = 16;
  localparam int DATA_BITS    = 8;
  localparam int FRAME_BITS   = 10;
  localparam int START_SAMPLE = 7;

  localparam logic RATE_SLOW = 1'b0;
  localparam logic RATE_FAST = 1'b1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;
endpackage

// File: rtl/serial_byte_fifo.sv
// serial_byte_fifo: synchronous FIFO, first-word-fall-through read port.
//   clk, reset  clock / synchronous active-high reset (empties the FIFO)
//   wr, din     write strobe and data; ignored while full
//   rd, dout    pop strobe and head-of-queue data; pop ignored while empty
//   full, empty occupancy flags
module serial_byte_fifo #(
  parameter int AW = 3,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr_en, rd_en;

  // full is judged before the pop, so write+pop while full rejects the write
  assign full  = (cnt == (AW+1)'(2**AW));
  assign empty = (cnt == '0);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/acia_serial_peer.sv
// acia_serial_peer: device end of an ACIA 8N1 link (IKBD/MIDI endpoint model).
//   clk, reset      system clock, synchronous active-high reset
//   rate_sel        0 = slow divider, 1 = fast divider (change only when idle)
//   rx              serial in from the ACIA, async, idle high
//   tx              serial out to the ACIA, idle high
//   tx_data, tx_wr  byte + strobe into the TX FIFO; tx_full rejects writes
//   tx_busy         FIFO non-empty or a frame/gap in progress
//   rx_data/rx_valid/rx_ack  received byte handshake
//   rx_overrun      sticky, byte dropped because rx_valid was still set
//   rx_frame_err    last frame had a 0 stop bit; cleared by the next good frame
//   rx_busy         receiver inside a frame
module acia_serial_peer
  import serial_pkg::*;
#(
  parameter int DIV_FAST = 64,
  parameter int DIV_SLOW = 256,
  parameter int FIFO_AW  = 3,
  parameter int GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rate_sel,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int DIVW    = $clog2(DIV_MAX);

  // ---- prescaler: 1-clk tick every DIV clocks
  logic [DIVW-1:0] pre_cnt, div_m1;
  logic            tick;

  assign div_m1 = (rate_sel == RATE_FAST) ? DIVW'(DIV_FAST-1) : DIVW'(DIV_SLOW-1);

  // >= rather than == so a fast switch with a large count still wraps
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt >= div_m1) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // ---- rx front end: synchronizer + 4-sample majority-of-all filter
  logic       rx_meta, rx_s, rx_filt;
  logic [3:0] rx_samp, samp_next;

  assign samp_next = {rx_samp[2:0], rx_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_samp <= 4'hF;
      rx_filt <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (tick) begin
        rx_samp <= samp_next;
        if (samp_next == 4'h0)      rx_filt <= 1'b0;
        else if (samp_next == 4'hF) rx_filt <= 1'b1;
      end
    end
  end

  // ---- rx FSM + delivery
  rx_state_t  rx_state;
  logic [3:0] rx_sub;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_done;

  assign rx_busy = (rx_state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_sub       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_done      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: if (!rx_filt) begin
            rx_state <= RX_START;
            rx_sub   <= '0;
          end
          RX_START: if (rx_sub == 4'(START_SAMPLE)) begin
            if (rx_filt) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_sub   <= '0;
              rx_bit   <= '0;
            end
          end else rx_sub <= rx_sub + 1'b1;
          RX_DATA: if (rx_sub == 4'(SUBBITS-1)) begin
            rx_sub   <= '0;
            rx_shift <= {rx_filt, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'(DATA_BITS-1)) rx_state <= RX_STOP;
          end else rx_sub <= rx_sub + 1'b1;
          RX_STOP: if (rx_sub == 4'(SUBBITS-1)) begin
            if (rx_filt) begin
              rx_done      <= 1'b1;
              rx_frame_err <= 1'b0;
              rx_state     <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_BREAK;
            end
          end else rx_sub <= rx_sub + 1'b1;
          // hold here until the line is released so a stuck-low line can't retrigger
          RX_BREAK: if (rx_filt) rx_state <= RX_IDLE;
          default:  rx_state <= RX_IDLE;
        endcase
      end

      // ack is applied first; a same-cycle delivery then loads without overrun
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (rx_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else rx_overrun <= 1'b1;
      end
    end
  end

  // ---- tx FIFO + FSM
  logic       fifo_empty, pop, frame_end, gap_end;
  logic [7:0] fifo_dout;
  tx_state_t  tx_state;
  logic [3:0] tx_sub;
  logic [7:0] tx_bit;
  logic [9:0] tx_shift;

  serial_byte_fifo #(.AW(FIFO_AW), .W(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .din   (tx_data),
    .rd    (pop),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  assign frame_end = (tx_sub == 4'(SUBBITS-1)) && (tx_bit == 8'(FRAME_BITS-1));
  assign gap_end   = (tx_sub == 4'(SUBBITS-1)) && (tx_bit == 8'(GAP_BITS-1));
  // chain straight into the next frame at the end of stop/gap so no idle tick is inserted
  assign pop = tick && !fifo_empty &&
               ((tx_state == TX_IDLE) ||
                (tx_state == TX_SHIFT && frame_end && GAP_BITS == 0) ||
                (tx_state == TX_GAP && gap_end));
  assign tx      = tx_shift[0];
  assign tx_busy = !fifo_empty || (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else if (tick) begin
      if (pop) begin
        tx_state <= TX_SHIFT;
        tx_shift <= {1'b1, fifo_dout, 1'b0};
        tx_sub   <= '0;
        tx_bit   <= '0;
      end else begin
        case (tx_state)
          TX_SHIFT: if (tx_sub == 4'(SUBBITS-1)) begin
            tx_sub   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (frame_end) begin
              tx_bit   <= '0;
              tx_state <= (GAP_BITS == 0) ? TX_IDLE : TX_GAP;
            end else tx_bit <= tx_bit + 1'b1;
          end else tx_sub <= tx_sub + 1'b1;
          TX_GAP: if (tx_sub == 4'(SUBBITS-1)) begin
            tx_sub <= '0;
            if (gap_end) tx_state <= TX_IDLE;
            else         tx_bit   <= tx_bit + 1'b1;
          end else tx_sub <= tx_sub + 1'b1;
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_acia_serial_peer.sv
// Bench for acia_serial_peer: drives 8N1 frames on rx, decodes tx, and compares
// against a frame-level model of the link (byte queue + handshake flags).
module tb_acia_serial_peer;
  localparam int DIV_FAST = 16;
  localparam int DIV_SLOW = 32;

  logic       clk = 1'b0, reset = 1'b1, rate_sel = 1'b1, rx = 1'b1;
  logic       tx, tx_wr = 1'b0, tx_full, tx_busy;
  logic [7:0] tx_data = '0, rx_data;
  logic       rx_valid, rx_ack = 1'b0, rx_overrun, rx_frame_err, rx_busy;

  int n_chk = 0, n_err = 0;
  int bt = 16*DIV_FAST;
  int cyc = 0, busy_cnt = 0, tx_low_cnt = 0;

  // frame-level model of the receive side
  logic       m_valid = 1'b0, m_over = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_data = '0;

  acia_serial_peer #(.DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .FIFO_AW(3), .GAP_BITS(0)) dut (
    .clk(clk), .reset(reset), .rate_sel(rate_sel), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_busy)   busy_cnt   <= busy_cnt + 1;
    if (tx !== 1)  tx_low_cnt <= tx_low_cnt + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    m_valid = 0; m_over = 0; m_ferr = 0; m_data = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output logic early);
    rx = 1'b0;
    clks(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(bt);
    end
    early = rx_valid;
    rx = stop_bit;
    clks(bt);
    rx = 1'b1;
    if (stop_bit) begin
      if (!m_valid) begin m_data = b; m_valid = 1'b1; end
      else m_over = 1'b1;
      m_ferr = 1'b0;
    end else m_ferr = 1'b1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    clks(1);
    rx_ack = 1'b0;
    if (m_valid) begin m_valid = 1'b0; m_over = 1'b0; end
  endtask

  task automatic rx_check(input string t);
    chk({t, "_valid"}, rx_valid, m_valid);
    chk({t, "_data"},  rx_data,  m_data);
    chk({t, "_over"},  rx_overrun, m_over);
    chk({t, "_ferr"},  rx_frame_err, m_ferr);
    chk({t, "_busy"},  rx_busy, 0);
  endtask

  // decode one frame from tx: find the start edge, then sample mid-bit
  task automatic get_tx_frame(output logic [7:0] b, output int edge_cyc, output logic start_b, output logic stop_b);
    int n = 0;
    while (tx !== 1'b0 && n < 20*bt) begin clks(1); n++; end
    if (n >= 20*bt) chk("tx_edge_timeout", n, 0);
    edge_cyc = cyc;
    clks(bt/2);
    start_b = tx;
    for (int i = 0; i < 8; i++) begin clks(bt); b[i] = tx; end
    clks(bt);
    stop_b = tx;
  endtask

  initial begin
    logic       early, full8, st, sp;
    logic [7:0] b, got;
    logic [7:0] q[$];
    int         e, prev_e, wr_cyc, c0;

    // reset state
    do_reset();
    clks(2);
    chk("rst_tx", tx, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_tx_busy", tx_busy, 0);
    rx_check("rst");

    // T1: 0xA5 then a few random bytes at the fast rate
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, early);
      chk("t1_early_valid", early, 0);
      clks(bt);
      rx_check("t1");
      ack();
      rx_check("t1_ack");
    end

    // T2: two frames without ack -> overrun, first byte kept
    send_frame(8'h12, 1'b1, early);
    send_frame(8'h34, 1'b1, early);
    clks(bt);
    rx_check("t2");
    ack();
    rx_check("t2_ack");

    // T3: framing error then a good frame clears it
    send_frame(8'h55, 1'b0, early);
    clks(2*bt);
    rx_check("t3_err");
    send_frame(8'h00, 1'b1, early);
    clks(bt);
    rx_check("t3_good");
    ack();

    // T4: short glitch ignored; 5-tick pulse is a false start
    c0 = busy_cnt;
    rx = 1'b0; clks(3*DIV_FAST/2); rx = 1'b1;
    clks(2*bt);
    chk("t4_glitch_busy", busy_cnt - c0, 0);
    chk("t4_glitch_valid", rx_valid, m_valid);
    c0 = busy_cnt;
    rx = 1'b0; clks(5*DIV_FAST); rx = 1'b1;
    clks(2*bt);
    chk("t4_pulse_started", (busy_cnt - c0) > 0, 1);
    chk("t4_pulse_idle", rx_busy, 0);
    chk("t4_pulse_valid", rx_valid, m_valid);

    // T5: 9 writes into an 8-deep FIFO right after reset; 8 frames back to back
    do_reset();
    q.delete();
    full8 = 1'b0;
    wr_cyc = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_data = b;
      tx_wr = 1'b1;
      if (q.size() < 8) q.push_back(b);
      clks(1);
      if (i == 0) wr_cyc = cyc;
      if (i == 7) full8 = tx_full;
    end
    tx_wr = 1'b0;
    chk("t5_full_at8", full8, 1);
    chk("t5_full_at9", tx_full, 1);
    prev_e = 0;
    for (int f = 0; f < 8; f++) begin
      get_tx_frame(got, e, st, sp);
      chk($sformatf("t5_start%0d", f), st, 0);
      chk($sformatf("t5_byte%0d", f), got, q[f]);
      chk($sformatf("t5_stop%0d", f), sp, 1);
      if (f == 0) chk("t5_first_edge_prompt", (e - wr_cyc) <= DIV_FAST + 2, 1);
      else        chk($sformatf("t5_period%0d", f), e - prev_e, 10*bt);
      prev_e = e;
    end
    clks(2*bt);
    chk("t5_done_busy", tx_busy, 0);
    chk("t5_done_tx", tx, 1);
    chk("t5_done_full", tx_full, 0);

    // T6: slow rate, reset in the middle of a frame
    reset = 1'b1;
    rate_sel = 1'b0;
    bt = 16*DIV_SLOW;
    clks(2);
    reset = 1'b0;
    tx_data = 8'h80;
    tx_wr = 1'b1;
    clks(1);
    tx_wr = 1'b0;
    clks(3*bt);
    chk("t6_mid_busy", tx_busy, 1);
    chk("t6_mid_tx", tx, 0);
    reset = 1'b1;
    clks(1);
    chk("t6_rst_tx", tx, 1);
    chk("t6_rst_busy", tx_busy, 0);
    chk("t6_rst_full", tx_full, 0);
    reset = 1'b0;
    c0 = tx_low_cnt;
    clks(2*bt);
    chk("t6_no_resend", tx_low_cnt - c0, 0);
    chk("t6_idle_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
